av_head_scheduler: RTL and testbench

- Shares one attention A*V multiply engine between NUM_HEADS attention-head requesters using round-robin arbitration.
- For each granted head, scans that head's attention matrix column by column and derives a per-column precision code (INT4/INT8/FP16) from the column's peak magnitude.
- Then pulses the engine start, waits for engine done (with timeout), and acknowledges the head.
- Sits between the head-level softmax/attention buffers and the shared A*V multiply engine.

---
 rtl/av_head_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_av_head_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/av_head_scheduler.sv
// av_head_scheduler: round-robin arbiter that lends one shared A*V multiply
// engine to NUM_HEADS attention heads. For each granted head it scans the
// attention matrix column by column, derives a precision code per column
// from the column's peak magnitude, launches the engine and acknowledges.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for any request; grants and latches thresholds
//   SCAN   | column-major reads of the head's matrix, codes built
//   LAUNCH | one-cycle engine start pulse
//   WAIT   | waiting for engine done, bounded by a timeout down-counter
//   ACK    | one-cycle ack to the granted head (err if timed out)
module av_head_scheduler #(
   parameter  int NUM_HEADS   = 4,
   parameter  int A_ROWS      = 8,
   parameter  int NUM_COLS    = 8,
   parameter  int TIMEOUT_CYC = 4096,
   localparam int HEAD_W      = $clog2(NUM_HEADS),
   localparam int ADDR_W      = (A_ROWS * NUM_COLS > 1) ? $clog2(A_ROWS * NUM_COLS) : 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [NUM_HEADS-1:0]    i_req,
   output logic [NUM_HEADS-1:0]    o_ack,
   output logic                    o_err,
   output logic                    o_busy,
   input  logic [15:0]             i_thr_int4,
   input  logic [15:0]             i_thr_int8,
   output logic [HEAD_W-1:0]       o_rd_head,
   output logic [ADDR_W-1:0]       o_rd_addr,
   output logic                    o_rd_en,
   input  logic [15:0]             i_rd_data,
   output logic [HEAD_W-1:0]       o_eng_head,
   output logic [2*NUM_COLS-1:0]   o_precision_sel,
   output logic                    o_eng_start,
   input  logic                    i_eng_done
);

   localparam int ROW_W = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
   localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SCAN   = 3'd1;
   localparam logic [2:0] S_LAUNCH = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_ACK    = 3'd4;

   logic [2:0]            r_state;
   logic [HEAD_W-1:0]     r_rr_ptr;
   logic [HEAD_W-1:0]     r_head;
   logic [15:0]           r_thr4;
   logic [15:0]           r_thr8;
   logic [ROW_W-1:0]      r_row;
   logic [COL_W-1:0]      r_col;
   logic [ADDR_W-1:0]     r_addr;
   logic                  r_issuing;
   logic                  r_cap_vld;
   logic [ROW_W-1:0]      r_cap_row;
   logic [COL_W-1:0]      r_cap_col;
   logic [15:0]           r_col_max;
   logic [2*NUM_COLS-1:0] r_prec;
   logic [TMR_W-1:0]      r_tmr;
   logic                  r_timeout;

   logic                  w_grant_vld;
   logic [HEAD_W-1:0]     w_grant;
   logic [15:0]           w_mag;
   logic [15:0]           w_new_max;
   logic [1:0]            w_code;

   function automatic logic [HEAD_W-1:0] rr_index(input logic [HEAD_W-1:0] ptr, input int off);
      int k;
      k = int'(ptr) + off;
      if (k >= NUM_HEADS) k = k - NUM_HEADS;
      return HEAD_W'(k);
   endfunction

   // Round-robin pick: lowest offset from the pointer wins, so scan offsets high to low.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant     = '0;
      for (int i = NUM_HEADS - 1; i >= 0; i--) begin
         if (i_req[rr_index(r_rr_ptr, i)]) begin
            w_grant_vld = 1'b1;
            w_grant     = rr_index(r_rr_ptr, i);
         end
      end
   end

   // Saturating magnitude of the captured element, running column max and its code.
   always_comb begin
      if (i_rd_data == 16'h8000)
         w_mag = 16'h7FFF;
      else if (i_rd_data[15])
         w_mag = (~i_rd_data) + 16'd1;
      else
         w_mag = i_rd_data;

      if ((r_cap_row == '0) || (w_mag > r_col_max))
         w_new_max = w_mag;
      else
         w_new_max = r_col_max;

      if (w_new_max < r_thr4)
         w_code = 2'b00;
      else if (w_new_max < r_thr8)
         w_code = 2'b01;
      else
         w_code = 2'b10;
   end

   // Main sequencer: grant, scan/capture pipeline, launch, timed wait, acknowledge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_rr_ptr  <= '0;
         r_head    <= '0;
         r_thr4    <= '0;
         r_thr8    <= '0;
         r_row     <= '0;
         r_col     <= '0;
         r_addr    <= '0;
         r_issuing <= 1'b0;
         r_cap_vld <= 1'b0;
         r_cap_row <= '0;
         r_cap_col <= '0;
         r_col_max <= '0;
         r_prec    <= '0;
         r_tmr     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_cap_vld <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_vld) begin
                  r_head    <= w_grant;
                  r_thr4    <= i_thr_int4;
                  r_thr8    <= i_thr_int8;
                  r_row     <= '0;
                  r_col     <= '0;
                  r_addr    <= '0;
                  r_issuing <= 1'b1;
                  r_timeout <= 1'b0;
                  r_state   <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (r_issuing) begin
                  r_cap_vld <= 1'b1;
                  r_cap_row <= r_row;
                  r_cap_col <= r_col;
                  if (r_row == ROW_W'(A_ROWS - 1)) begin
                     r_row  <= '0;
                     r_col  <= r_col + COL_W'(1);
                     r_addr <= ADDR_W'(r_col) + ADDR_W'(1);
                     if (r_col == COL_W'(NUM_COLS - 1)) r_issuing <= 1'b0;
                  end else begin
                     r_row  <= r_row + ROW_W'(1);
                     r_addr <= r_addr + ADDR_W'(NUM_COLS);
                  end
               end
               if (r_cap_vld) begin
                  r_col_max <= w_new_max;
                  if (r_cap_row == ROW_W'(A_ROWS - 1)) begin
                     r_prec[2*r_cap_col +: 2] <= w_code;
                     if (r_cap_col == COL_W'(NUM_COLS - 1)) r_state <= S_LAUNCH;
                  end
               end
            end
            S_LAUNCH: begin
               r_tmr   <= TMR_W'(TIMEOUT_CYC - 1);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (i_eng_done) begin
                  r_state <= S_ACK;
               end else if (r_tmr == '0) begin
                  r_timeout <= 1'b1;
                  r_state   <= S_ACK;
               end else begin
                  r_tmr <= r_tmr - TMR_W'(1);
               end
            end
            S_ACK: begin
               r_rr_ptr <= (r_head == HEAD_W'(NUM_HEADS - 1)) ? '0 : r_head + HEAD_W'(1);
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Output decode; read address is forced to zero outside active reads.
   always_comb begin
      o_ack = '0;
      if (r_state == S_ACK) o_ack[r_head] = 1'b1;
      o_err           = (r_state == S_ACK) && r_timeout;
      o_busy          = (r_state != S_IDLE);
      o_rd_en         = (r_state == S_SCAN) && r_issuing;
      o_rd_addr       = o_rd_en ? r_addr : '0;
      o_rd_head       = r_head;
      o_eng_head      = r_head;
      o_precision_sel = r_prec;
      o_eng_start     = (r_state == S_LAUNCH);
   end

endmodule

// File: tb/tb_av_head_scheduler.sv
// Self-checking bench for av_head_scheduler: directed scenarios plus
// randomized jobs compared against a behavioural model of the scheduler.
module tb_av_head_scheduler;
   localparam int NH = 4;
   localparam int AR = 8;
   localparam int NC = 8;
   localparam int TO = 16;
   localparam int NE = AR * NC;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NH-1:0]  req = '0;
   logic [NH-1:0]  ack;
   logic           err;
   logic           busy;
   logic [15:0]    thr4 = '0;
   logic [15:0]    thr8 = '0;
   logic [1:0]     rd_head;
   logic [5:0]     rd_addr;
   logic           rd_en;
   logic [15:0]    rd_data;
   logic [1:0]     eng_head;
   logic [2*NC-1:0] prec;
   logic           eng_start;
   logic           eng_done = 1'b0;

   int checks = 0;
   int errors = 0;
   int n_start = 0;
   int n_ack = 0;
   int n_err = 0;
   int mrr = 0;
   logic [7:0]  rdq[$];
   logic [15:0] mem[NH][NE];
   logic [15:0] pend = '0;
   bit          pend_vld = 1'b0;

   av_head_scheduler #(.NUM_HEADS(NH), .A_ROWS(AR), .NUM_COLS(NC), .TIMEOUT_CYC(TO)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .o_ack(ack), .o_err(err), .o_busy(busy),
      .i_thr_int4(thr4), .i_thr_int8(thr8), .o_rd_head(rd_head), .o_rd_addr(rd_addr),
      .o_rd_en(rd_en), .i_rd_data(rd_data), .o_eng_head(eng_head), .o_precision_sel(prec),
      .o_eng_start(eng_start), .i_eng_done(eng_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Attention buffer: data for a read appears one cycle later, garbage otherwise.
   always @(negedge clk) begin
      rd_data  = pend_vld ? pend : 16'($urandom);
      pend_vld = rd_en;
      pend     = mem[rd_head][rd_addr];
   end

   // Bus monitor: read log, pulse counters, ack one-hot property.
   always @(negedge clk) begin
      if (!rst) begin
         if (rd_en) rdq.push_back({rd_head, rd_addr});
         if (eng_start) n_start++;
         if (err) n_err++;
         if (ack != '0) begin
            n_ack++;
            check("ack_onehot", $countones(ack), 1);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic int mag(input logic [15:0] v);
      if (v == 16'h8000) return 32767;
      if (v[15]) return 65536 - int'(v);
      return int'(v);
   endfunction

   function automatic logic [15:0] model_prec(input int h, input int t4, input int t8);
      logic [15:0] res;
      int mx, m, code;
      res = '0;
      for (int c = 0; c < NC; c++) begin
         mx = 0;
         for (int r = 0; r < AR; r++) begin
            m = mag(mem[h][r*NC + c]);
            if (m > mx) mx = m;
         end
         code = (mx < t4) ? 0 : ((mx < t8) ? 1 : 2);
         res[2*c +: 2] = 2'(code);
      end
      return res;
   endfunction

   function automatic int pick(input logic [NH-1:0] mask, input int rr);
      for (int i = 0; i < NH; i++) begin
         if (mask[(rr + i) % NH]) return (rr + i) % NH;
      end
      return -1;
   endfunction

   task automatic fill_random(input int h);
      logic signed [15:0] sv;
      for (int i = 0; i < NE; i++) begin
         sv = 16'($urandom);
         mem[h][i] = 16'(sv >>> $urandom_range(0, 4));
         if ($urandom_range(0, 40) == 0) mem[h][i] = 16'h8000;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ack"}, ack, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_rd_en"}, rd_en, 0);
      check({tag, "_rd_addr"}, rd_addr, 0);
      check({tag, "_rd_head"}, rd_head, 0);
      check({tag, "_eng_head"}, eng_head, 0);
      check({tag, "_prec"}, prec, 0);
      check({tag, "_start"}, eng_start, 0);
   endtask

   // One job from grant to the idle cycle after ack. d>0: done on the d-th cycle after start; d<0: never.
   task automatic run_job(input int exp_head, input int d, input bit mid, input bit drop, output int gw);
      int cyc, k, s0, a0, e0, bad, c, r;
      logic [15:0] lt4, lt8, exp_p;
      logic [7:0]  exp_rd;
      rdq.delete();
      s0 = n_start; a0 = n_ack; e0 = n_err;
      gw = 0;
      while (!busy && gw < 20) begin tick(); gw++; end
      check("grant_seen", busy, 1);
      if (!busy) return;
      check("rd_head", rd_head, exp_head);
      check("eng_head", eng_head, exp_head);
      lt4 = thr4; lt8 = thr8;
      exp_p = model_prec(exp_head, lt4, lt8);
      if (drop) req = '0;
      cyc = 0;
      while (!eng_start && cyc < 200) begin
         if (mid && cyc == 20) begin
            thr4 = 16'h7FFF - lt4;
            thr8 = 16'h0100;
            eng_done = 1'b1;
         end else begin
            eng_done = 1'b0;
         end
         tick();
         cyc++;
      end
      eng_done = 1'b0;
      check("launch_cyc", cyc, NE + 1);
      check("prec_launch", prec, exp_p);
      k = 0;
      while (k < 40) begin
         tick();
         k++;
         eng_done = (k == d);
         if (ack != '0) break;
      end
      eng_done = 1'b0;
      check("ack_cyc", k, (d > 0) ? d + 1 : TO + 1);
      check("ack_val", ack, 1 << exp_head);
      check("err_val", err, (d > 0) ? 0 : 1);
      check("prec_hold", prec, exp_p);
      bad = (rdq.size() != NE) ? 1 : 0;
      for (int i = 0; i < rdq.size() && i < NE; i++) begin
         c = i / AR; r = i % AR;
         exp_rd = {exp_head[1:0], 6'(r*NC + c)};
         if (rdq[i] !== exp_rd) bad++;
      end
      check("rd_seq_bad", bad, 0);
      tick();
      check("busy_gap", busy, 0);
      check("start_cnt", n_start - s0, 1);
      check("ack_cnt", n_ack - a0, 1);
      check("err_cnt", n_err - e0, (d > 0) ? 0 : 1);
      mrr = (exp_head + 1) % NH;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      mrr = 0;
   endtask

   initial begin
      int gw, h, a0, d;
      logic [NH-1:0] mask;
      for (int hh = 0; hh < NH; hh++) fill_random(hh);
      rst = 1'b1;
      repeat (3) tick();
      check_zero("reset");
      rst = 1'b0;

      // Uniform small data, well below both thresholds.
      for (int i = 0; i < NE; i++) mem[0][i] = 16'h1000;
      thr4 = 16'h2000; thr8 = 16'h4000; req = 4'b0001;
      run_job(pick(req, mrr), 10, 1'b0, 1'b0, gw);
      req = '0;
      check("t1_prec", prec, 16'h0000);

      // Staircase of column peaks, including a saturating 0x8000 in the last column.
      for (int c = 0; c < NC; c++) begin
         for (int r = 0; r < AR; r++) mem[2][r*NC + c] = 16'h0100;
         mem[2][3*NC + c] = 16'(16'h0800 * (c + 1));
         mem[2][5*NC + c] = 16'(65536 - 16'h0800 * (c + 1));
      end
      mem[2][6*NC + 7] = 16'h8000;
      thr4 = 16'h1800; thr8 = 16'h3000; req = 4'b0100;
      run_job(pick(req, mrr), 5, 1'b0, 1'b0, gw);
      req = '0;
      check("t2_prec", prec, 16'hA950);

      // All heads requesting: round-robin from a fresh pointer, one idle cycle between jobs.
      do_reset();
      req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         h = pick(req, mrr);
         check("rr_order", h, j % NH);
         run_job(h, $urandom_range(1, 15), 1'b0, 1'b0, gw);
         if (j > 0) check("rr_regrant_gap", gw, 1);
      end
      req = '0;

      // Engine never answers: timeout, then a normal job.
      req = 4'b0010;
      run_job(pick(req, mrr), -1, 1'b0, 1'b1, gw);
      req = 4'b1000;
      run_job(pick(req, mrr), 3, 1'b0, 1'b0, gw);
      req = '0;

      // Reset in the middle of a scan aborts without ack; the job restarts from address 0.
      do_reset();
      fill_random(1);
      req = 4'b0010;
      gw = 0;
      while (!busy && gw < 20) begin tick(); gw++; end
      repeat (10) tick();
      a0 = n_ack;
      rst = 1'b1;
      tick();
      check_zero("midrst");
      rst = 1'b0;
      mrr = 0;
      check("midrst_no_ack", n_ack, a0);
      run_job(1, 4, 1'b0, 1'b0, gw);
      req = '0;

      // Threshold change and stray done during scan.
      fill_random(2);
      thr4 = 16'h0800; thr8 = 16'h2000; req = 4'b0100;
      run_job(pick(req, mrr), 8, 1'b1, 1'b0, gw);
      req = '0;

      // Inverted thresholds: INT4 test keeps priority.
      fill_random(3);
      thr4 = 16'h2000; thr8 = 16'h0400; req = 4'b1000;
      run_job(pick(req, mrr), 2, 1'b0, 1'b0, gw);
      req = '0;

      // Randomized jobs.
      for (int j = 0; j < 10; j++) begin
         for (int hh = 0; hh < NH; hh++) fill_random(hh);
         thr4 = 16'($urandom_range(0, 32768));
         thr8 = 16'($urandom_range(0, 32768));
         mask = NH'($urandom_range(1, (1 << NH) - 1));
         req = mask;
         d = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(1, 15);
         run_job(pick(mask, mrr), d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), gw);
         req = '0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
